// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Booth recoding of {b0, guard}: 01 adds A, 10 subtracts A.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    unique case (pair)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

  // Operands are extended by one bit, so a WIDTH-bit multiply takes WIDTH+1 steps.
  function automatic int iter_count(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub into the upper half, then arithmetic shift.
module booth_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+2:0] p,
  input  logic [WIDTH:0]     a,
  output logic [2*WIDTH+2:0] p_next
);

  logic [WIDTH+1:0] upper_ext;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] sum;

  // The extra sum bit keeps A = most-negative from overflowing; its MSB becomes the shifted-in sign.
  always_comb begin
    upper_ext = {p[2*WIDTH+2], p[2*WIDTH+2:WIDTH+2]};
    a_ext     = {a[WIDTH], a};
    sum       = upper_ext;
    unique case (booth_decode(p[1:0]))
      BOOTH_ADD: sum = upper_ext + a_ext;
      BOOTH_SUB: sum = upper_ext - a_ext;
      default:   sum = upper_ext;
    endcase
    p_next = {sum, p[WIDTH+1:1]};
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier, signed/unsigned, with start/busy/done handshake.
module seq_booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int PW    = 2 * WIDTH + 3;
  localparam logic [CNT_W-1:0] ITER = CNT_W'(iter_count(WIDTH));

  state_t           state;
  logic [WIDTH:0]   a_reg;
  logic [PW-1:0]    p_reg;
  logic [PW-1:0]    p_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;

  // One extension rule serves both modes: sign bit when signed, zero otherwise.
  always_comb begin
    ext_a = {is_signed & multiplicand[WIDTH-1], multiplicand};
    ext_b = {is_signed & multiplier[WIDTH-1], multiplier};
  end

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .p_next (p_next)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      zhigh <= '0;
      zlow  <= '0;
      cnt   <= '0;
      a_reg <= '0;
      p_reg <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= ext_a;
            p_reg <= {{(WIDTH+1){1'b0}}, ext_b, 1'b0};
            cnt   <= ITER;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          p_reg <= p_next;
          cnt   <= cnt - 1'b1;
          // Final step: capture the product straight from the step output so done and data align.
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            zhigh <= p_next[2*WIDTH:WIDTH+1];
            zlow  <= p_next[WIDTH:1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed self-checking bench for seq_booth_multiplier at WIDTH=32 and WIDTH=8.
module tb_seq_booth_multiplier;

  logic        clock = 1'b0;
  logic        clear = 1'b0;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] zh32, zl32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  zh8, zl8;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  seq_booth_multiplier #(.WIDTH(32)) d32 (
    .clock(clock), .clear(clear), .start(start32), .is_signed(sgn32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .zhigh(zh32), .zlow(zl32)
  );

  seq_booth_multiplier #(.WIDTH(8)) d8 (
    .clock(clock), .clear(clear), .start(start8), .is_signed(sgn8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .zhigh(zh8), .zlow(zl8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Issue one 32-bit multiply; start stays high (with scrambled operands) for `hold` extra edges.
  task automatic op32(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold,
                      output int lat, output logic hs_ok);
    @(negedge clock);
    sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    @(negedge clock);
    lat = 0; hs_ok = busy32 & ~done32;
    if (hold > 0) begin a32 = ~a; b32 = ~b; sgn32 = ~sgn; end
    else start32 = 1'b0;
    while (!done32 && lat < 60) begin
      @(negedge clock);
      lat++;
      if (lat >= hold) start32 = 1'b0;
      if (!done32 && !busy32) hs_ok = 1'b0;
      if (done32 && busy32) hs_ok = 1'b0;
    end
  endtask

  task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clock);
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0; lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int lat, lat2;
    logic ok, saw_done;
    logic [7:0] vals [6];
    logic [15:0] ref8;

    // Reset state
    #12;
    check("reset_busy", {63'd0, busy32}, 64'd0);
    check("reset_done", {63'd0, done32}, 64'd0);
    check("reset_prod", {zh32, zl32}, 64'd0);
    @(negedge clock); clear = 1'b1;

    // 1: signed 18 * -13, start held during RUN
    op32(1'b1, 32'h0000_0012, 32'hFFFF_FFF3, 4, lat, ok);
    check("t1_latency", 64'(lat), 64'd33);
    check("t1_handshake", {63'd0, ok}, 64'd1);
    check("t1_prod", {zh32, zl32}, 64'hFFFF_FFFF_FFFF_FF16);
    @(negedge clock);
    check("t1_done_pulse", {62'd0, done32, busy32}, 64'd0);

    // 2: mode split on all-ones
    op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, ok);
    check("t2_unsigned", {zh32, zl32}, 64'hFFFF_FFFE_0000_0001);
    op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, ok);
    check("t2_signed", {zh32, zl32}, 64'h0000_0000_0000_0001);

    // 3: most-negative corners
    op32(1'b1, 32'h8000_0000, 32'h8000_0000, 0, lat, ok);
    check("t3_minsq", {zh32, zl32}, 64'h4000_0000_0000_0000);
    op32(1'b1, 32'h8000_0000, 32'h0000_0001, 0, lat, ok);
    check("t3_min_x1", {zh32, zl32}, 64'hFFFF_FFFF_8000_0000);

    // 5: back-to-back, 3*4 then 5*6 with start held through DONE
    op32(1'b0, 32'd3, 32'd4, 0, lat, ok);
    check("t5_first", {zh32, zl32}, 64'd12);
    a32 = 32'd5; b32 = 32'd6; sgn32 = 1'b0; start32 = 1'b1;
    @(negedge clock);
    check("t5_no_gap", {62'd0, busy32, done32}, 64'd2);
    start32 = 1'b0; lat2 = 1;
    while (!done32 && lat2 < 60) begin
      @(negedge clock);
      lat2++;
      if (lat2 == 10) check("t5_hold", {zh32, zl32}, 64'd12);
    end
    check("t5_latency", 64'(lat2), 64'd34);
    check("t5_second", {zh32, zl32}, 64'd30);

    // 4: reset mid-operation
    @(negedge clock);
    a32 = 32'd7; b32 = 32'd9; sgn32 = 1'b0; start32 = 1'b1;
    @(negedge clock); start32 = 1'b0;
    repeat (9) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    check("t4_rst_busy", {63'd0, busy32}, 64'd0);
    check("t4_rst_prod", {zh32, zl32}, 64'd0);
    @(negedge clock); clear = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done32 || busy32) saw_done = 1'b1;
    end
    check("t4_no_done", {63'd0, saw_done}, 64'd0);
    op32(1'b0, 32'd7, 32'd9, 0, lat, ok);
    check("t4_restart_lat", 64'(lat), 64'd33);
    check("t4_restart", {zh32, zl32}, 64'h3F);

    // 6: WIDTH=8 instance
    op8(1'b1, 8'h80, 8'hFF, lat);
    check("t6_latency", 64'(lat), 64'd9);
    check("t6_prod", {48'd0, zh8, zl8}, 64'h0080);
    vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          op8(m[0], vals[i], vals[j], lat);
          if (m[0]) ref8 = $signed({{8{vals[i][7]}}, vals[i]}) * $signed({{8{vals[j][7]}}, vals[j]});
          else      ref8 = {8'd0, vals[i]} * {8'd0, vals[j]};
          check($sformatf("w8_%s_%h_%h", m[0] ? "s" : "u", vals[i], vals[j]),
                {48'd0, zh8, zl8}, {48'd0, ref8});
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
